// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer: oversampled start/data/parity/stop framing with a one-word output slot.
// Latency: rx_in reaches the FSM 2 cycles late; strobes and the delivered word appear the cycle after each bit sample.
// Backpressure: a frame completing while the slot is held (rx_valid & ~rx_ready) is dropped and overrun_error is set.
//
// Ports:
//   rx_clk, rx_rst_n         clock, asynchronous active-low reset
//   rx_in                    asynchronous serial line, idle high
//   baud_tick                single-cycle oversample enable (OVERSAMPLE ticks per bit)
//   rx_ready                 consumer accepts rx_data when rx_valid & rx_ready
//   shift/parity_load/check_stop  single-cycle datapath strobes, one cycle after the matching sample
//   rx_data, rx_valid        received word and its valid flag
//   parity_bit_error, stop_bit_error  per-frame error flags, meaningful while rx_valid=1
//   overrun_error            sticky; set when a frame is dropped, cleared after the next acceptance
//   busy                     FSM is not idle
module uart_rx_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                  rx_clk,
  input  logic                  rx_rst_n,
  input  logic                  rx_in,
  input  logic                  baud_tick,
  input  logic                  rx_ready,
  output logic                  shift,
  output logic                  parity_load,
  output logic                  check_stop,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  parity_bit_error,
  output logic                  stop_bit_error,
  output logic                  overrun_error,
  output logic                  busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [SW-1:0] SMP_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
  localparam logic          PAR_ODD  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                r_state;
  logic                  r_sync1;
  logic                  r_sync2;
  logic                  r_prev;
  logic [SW-1:0]         r_smp;
  logic [BW-1:0]         r_bits;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic                  r_perr;

  logic                  r_shift;
  logic                  r_pload;
  logic                  r_cstop;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_perr_o;
  logic                  r_serr_o;
  logic                  r_ovr;

  logic w_rx_s;
  logic w_fall;
  logic w_accept;
  logic w_slot_free;

  assign w_rx_s      = r_sync2;
  assign w_fall      = r_prev & ~w_rx_s;
  assign w_accept    = r_valid & rx_ready;
  // The slot can take a new word if empty or being drained in this same cycle.
  assign w_slot_free = ~r_valid | rx_ready;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  // Reset to 1 (idle line) so a reset release never looks like a start edge.
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      r_state  <= S_IDLE;
      r_smp    <= '0;
      r_bits   <= '0;
      r_shreg  <= '0;
      r_perr   <= 1'b0;
      r_shift  <= 1'b0;
      r_pload  <= 1'b0;
      r_cstop  <= 1'b0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_perr_o <= 1'b0;
      r_serr_o <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_shift <= 1'b0;
      r_pload <= 1'b0;
      r_cstop <= 1'b0;

      // Acceptance drains the slot and clears a pending overrun; a frame
      // delivered in the STOP branch below overrides the valid clear.
      if (w_accept) begin
        r_valid <= 1'b0;
        r_ovr   <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_state <= S_START;
            r_smp   <= '0;
            r_bits  <= '0;
          end
        end

        S_START: begin
          if (baud_tick) begin
            if (r_smp == SMP_HALF) begin
              r_smp   <= '0;
              // Line back high at mid start bit: glitch, not a frame.
              r_state <= w_rx_s ? S_IDLE : S_DATA;
            end else begin
              r_smp <= r_smp + 1'b1;
            end
          end
        end

        S_DATA: begin
          if (baud_tick) begin
            if (r_smp == SMP_LAST) begin
              r_smp   <= '0;
              // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
              r_shreg <= {w_rx_s, r_shreg[DATA_WIDTH-1:1]};
              r_bits  <= r_bits + 1'b1;
              r_shift <= 1'b1;
              if (r_bits == BIT_LAST) begin
                r_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
              end
            end else begin
              r_smp <= r_smp + 1'b1;
            end
          end
        end

        S_PARITY: begin
          if (baud_tick) begin
            if (r_smp == SMP_LAST) begin
              r_smp   <= '0;
              r_perr  <= (^r_shreg) ^ w_rx_s ^ PAR_ODD;
              r_pload <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_smp <= r_smp + 1'b1;
            end
          end
        end

        S_STOP: begin
          if (baud_tick) begin
            if (r_smp == SMP_LAST) begin
              r_smp   <= '0;
              r_bits  <= '0;
              r_cstop <= 1'b1;
              r_state <= S_IDLE;
              if (w_slot_free) begin
                r_data   <= r_shreg;
                r_valid  <= 1'b1;
                r_perr_o <= r_perr;
                r_serr_o <= ~w_rx_s;
              end else begin
                // Held word is kept intact; the new frame is lost.
                r_ovr <= 1'b1;
              end
            end else begin
              r_smp <= r_smp + 1'b1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_smp   <= '0;
          r_bits  <= '0;
        end
      endcase
    end
  end

  assign shift            = r_shift;
  assign parity_load      = r_pload;
  assign check_stop       = r_cstop;
  assign rx_data          = r_data;
  assign rx_valid         = r_valid;
  assign parity_bit_error = r_perr_o;
  assign stop_bit_error   = r_serr_o;
  assign overrun_error    = r_ovr;
  assign busy             = (r_state != S_IDLE);

endmodule

// File: doc/uart_rx_sequencer.md
UART_RX_SEQUENCER -- requirements
Module: uart_rx_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data bits per frame, sent LSB first.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, baud_tick pulses per bit period; legal values are even integers 8 to 32.
REQ-003 SHALL have parameter PARITY_EN, default 1, where 1 means a parity bit follows the data bits.
REQ-004 SHALL have parameter PARITY_ODD, default 0, where 0 selects even parity and 1 selects odd parity.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: rx_clk input 1 (rising edge) and rx_rst_n input 1.
REQ-006 SHALL have rx_in, input, 1 bit: asynchronous serial line, idle high.
REQ-007 SHALL have baud_tick, input, 1 bit: single-cycle oversample enable, synchronous to rx_clk.
REQ-008 SHALL have rx_ready, input, 1 bit: consumer accepts rx_data in any cycle where rx_valid and rx_ready are both high.
REQ-009 SHALL have shift, parity_load and check_stop, outputs, 1 bit each: single-cycle datapath strobes.
REQ-010 SHALL have rx_data, output, DATA_WIDTH bits: the received word.
REQ-011 SHALL have rx_valid, output, 1 bit: rx_data and its error flags are valid.
REQ-012 SHALL have parity_bit_error, stop_bit_error and overrun_error, outputs, 1 bit each: error flags.
REQ-013 SHALL have busy, output, 1 bit: the FSM is in any state other than IDLE.

Function
REQ-014 SHALL pass rx_in through a 2-flop synchronizer; all sampling, including edge detection, SHALL use the synchronized value rx_s.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY and STOP, with a sample counter of width clog2(OVERSAMPLE) and a bit counter of width clog2(DATA_WIDTH+1).
REQ-016 In IDLE, a 1-to-0 transition of rx_s SHALL cause a move to START and clear the sample counter; a line held low SHALL NOT retrigger.
REQ-017 The sample counter SHALL increment only on baud_tick; the counter and the FSM SHALL hold their values between ticks.
REQ-018 In START, on the baud_tick where the counter equals OVERSAMPLE/2-1: if rx_s=1, the FSM SHALL return to IDLE (false start, no strobe); otherwise it SHALL clear the counter and move to DATA.
REQ-019 In DATA, PARITY and STOP, the line SHALL be sampled on the baud_tick where the counter equals OVERSAMPLE-1, and the counter SHALL then wrap to 0.
REQ-020 At each DATA sample, rx_s SHALL be shifted into an internal register at the MSB end, the bit counter SHALL increment, and shift SHALL pulse high in the following cycle.
REQ-021 After DATA_WIDTH data samples, the FSM SHALL move to PARITY if PARITY_EN=1, otherwise to STOP.
REQ-022 At the PARITY sample, the sequencer SHALL latch perr = (XOR of the data bits XOR rx_s XOR PARITY_ODD) != 0, pulse parity_load in the following cycle, and move to STOP.
REQ-023 At the STOP sample, the sequencer SHALL latch serr = ~rx_s, pulse check_stop in the following cycle, and move to IDLE.
REQ-024 Frame delivery SHALL happen at the STOP sample. If the output slot is free, or is being accepted in that same cycle, rx_data, parity_bit_error and stop_bit_error SHALL load in the next cycle and rx_valid SHALL be 1.
REQ-025 If rx_valid=1 and rx_ready=0 at the STOP sample, the new frame SHALL be discarded, the held outputs SHALL remain unchanged, and overrun_error SHALL go to 1.
REQ-026 rx_valid SHALL clear on acceptance, unless a new frame loads in the same cycle.
REQ-027 overrun_error SHALL be sticky and SHALL clear on the cycle after the next acceptance.
REQ-028 The sequencer SHALL deliver frames that have parity or stop errors; the error flags SHALL be valid only while rx_valid=1.
REQ-029 At most one of shift, parity_load and check_stop SHALL be high in any cycle.
REQ-030 After the STOP sample, IDLE SHALL detect a new start edge no earlier than the next cycle; back-to-back frames SHALL be received without loss.

Reset
REQ-031 While rx_rst_n=0, the sequencer SHALL set: state IDLE, both counters 0, synchronizer flops 1, rx_data 0, and rx_valid, all error flags, all strobes and busy to 0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame with no strobes and no delivery.
REQ-033 After reset is released, reception SHALL require a fresh 1-to-0 edge on rx_s.

Verification
REQ-034 Bench SHALL cover: 8E1 frame carrying 0xA5 with correct parity, rx_ready=1 -> 8 shift pulses, 1 parity_load, 1 check_stop; rx_data=0xA5, rx_valid high for 1 cycle, all error flags 0.
REQ-035 Bench SHALL cover: rx_in low for 4 ticks, then high -> FSM returns to IDLE; no strobes; rx_valid stays 0.
REQ-036 Bench SHALL cover: frame 0x3C with the parity bit inverted -> rx_data=0x3C, parity_bit_error=1, stop_bit_error=0.
REQ-037 Bench SHALL cover: frame 0x81 with the stop bit driven 0 -> stop_bit_error=1; a following valid 0x42 frame received correctly once the line returns high.
REQ-038 Bench SHALL cover: frames 0x11 then 0x22 with rx_ready=0 -> rx_data stays 0x11, overrun_error=1; after rx_ready=1 is accepted, overrun_error=0.
REQ-039 Bench SHALL cover: rx_rst_n pulsed low during data bit 4 -> all outputs 0 immediately; next complete frame 0x5A received correctly.
